lse_simd_add_pipe: RTL

Pipelined, parametrised SIMD adder for log-space multiplication. It adds two WIDTH-bit operands as 1, 2 or 4 independent unsigned lanes. Each lane can optionally saturate, and reports per-lane overflow through both a per-result flag and sticky flags. It sits between the operand fetch stage and the LSE accumulation path, with valid/ready handshakes on both sides. It is the clocked, back-pressurable, saturating successor of the combinational SIMD log-adder.

---
 rtl/lse_simd_pkg.sv | 48 ++++
 rtl/lse_simd_seg_adder.sv | 37 +++
 rtl/lse_simd_add_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lse_simd_pkg.sv
// ============================================================================
// Module      : lse_simd_pkg
// Description : Lane-mode encoding and lane-geometry helpers for the SIMD
//               log-space adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lse_simd_pkg;

    typedef enum logic [1:0] {
        MODE_1X   = 2'b00,
        MODE_2X   = 2'b01,
        MODE_4X   = 2'b10,
        MODE_RSVD = 2'b11
    } simd_mode_e;

    localparam int c_MAX_WIDTH = 256;

    function automatic int lane_count(simd_mode_e mode);
        case (mode)
            MODE_2X: return 2;
            MODE_4X: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int lane_width(simd_mode_e mode, int width);
        return width / lane_count(mode);
    endfunction

    // Bit i is set when bit i is the first bit of a lane other than lane 0.
    function automatic logic [c_MAX_WIDTH-1:0] lane_cut_mask(simd_mode_e mode, int width);
        logic [c_MAX_WIDTH-1:0] mask;
        int                     lw;
        mask = '0;
        lw   = lane_width(mode, width);
        for (int i = 1; i < width; i++) begin
            if ((i % lw) == 0) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lse_simd_seg_adder.sv
// ============================================================================
// Module      : lse_simd_seg_adder
// Description : Combinational ripple adder whose carry chain is cut wherever
//               the cut mask is set, producing per-bit carry-outs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lse_simd_seg_adder #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    input  logic [W-1:0] i_cut,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_cout
);

    always_comb begin
        logic w_carry;
        o_sum   = '0;
        o_cout  = '0;
        w_carry = i_cin;
        for (int i = 0; i < W; i++) begin
            if (i_cut[i]) begin
                w_carry = 1'b0;
            end
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry   = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
            o_cout[i] = w_carry;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lse_simd_add_pipe.sv
// ============================================================================
// Module      : lse_simd_add_pipe
// Description : Two-stage, back-pressurable SIMD adder (1/2/4 unsigned lanes)
//               with optional per-lane saturation and sticky overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lse_simd_add_pipe
    import lse_simd_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       simd_mode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       ovf,
    output logic [3:0]       ovf_sticky,
    input  logic             clr_sticky
);

    localparam int c_HALF = WIDTH / 2;
    localparam int c_QTR  = WIDTH / 4;
    localparam logic [WIDTH-1:0] c_CUT_2X = WIDTH'(lane_cut_mask(MODE_2X, WIDTH));
    localparam logic [WIDTH-1:0] c_CUT_4X = WIDTH'(lane_cut_mask(MODE_4X, WIDTH));

    // Stage 1 state
    logic              r_s1_valid_q,  w_s1_valid_d;
    logic [c_HALF-1:0] r_s1_sum_lo_q, w_s1_sum_lo_d;
    logic              r_s1_c_qtr_q,  w_s1_c_qtr_d;
    logic              r_s1_c_half_q, w_s1_c_half_d;
    logic [c_HALF-1:0] r_s1_a_hi_q,   w_s1_a_hi_d;
    logic [c_HALF-1:0] r_s1_b_hi_q,   w_s1_b_hi_d;
    simd_mode_e        r_s1_mode_q,   w_s1_mode_d;
    logic              r_s1_sat_q,    w_s1_sat_d;

    // Stage 2 / output state
    logic              r_s2_valid_q,  w_s2_valid_d;
    logic [WIDTH-1:0]  r_result_q,    w_result_d;
    logic [3:0]        r_ovf_q,       w_ovf_d;
    logic [3:0]        r_sticky_q,    w_sticky_d;

    logic              w_s1_load;
    logic              w_s2_load;
    simd_mode_e        w_mode_in;
    logic [c_HALF-1:0] w_cut_lo;
    logic [c_HALF-1:0] w_cut_hi;
    logic [c_HALF-1:0] w_lo_sum;
    logic [c_HALF-1:0] w_lo_cout;
    logic [c_HALF-1:0] w_hi_sum;
    logic [c_HALF-1:0] w_hi_cout;
    logic              w_hi_cin;
    logic [WIDTH-1:0]  w_raw_sum;
    logic [WIDTH-1:0]  w_sat_result;
    logic [3:0]        w_lane_ovf;
    logic              w_qtr_ovf;
    logic              w_unused_cout;

    // Reserved mode behaves as a single full-width lane from capture onwards.
    always_comb begin
        w_mode_in = (simd_mode == MODE_RSVD) ? MODE_1X : simd_mode_e'(simd_mode);
        w_cut_lo  = '0;
        w_cut_hi  = '0;
        case (w_mode_in)
            MODE_2X: w_cut_lo = c_CUT_2X[c_HALF-1:0];
            MODE_4X: w_cut_lo = c_CUT_4X[c_HALF-1:0];
            default: w_cut_lo = '0;
        endcase
        case (r_s1_mode_q)
            MODE_2X: w_cut_hi = c_CUT_2X[WIDTH-1:c_HALF];
            MODE_4X: w_cut_hi = c_CUT_4X[WIDTH-1:c_HALF];
            default: w_cut_hi = '0;
        endcase
    end

    lse_simd_seg_adder #(.W(c_HALF)) u_add_lo (
        .i_a    (operand_a[c_HALF-1:0]),
        .i_b    (operand_b[c_HALF-1:0]),
        .i_cin  (1'b0),
        .i_cut  (w_cut_lo),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    assign w_hi_cin = (r_s1_mode_q == MODE_1X) ? r_s1_c_half_q : 1'b0;

    lse_simd_seg_adder #(.W(c_HALF)) u_add_hi (
        .i_a    (r_s1_a_hi_q),
        .i_b    (r_s1_b_hi_q),
        .i_cin  (w_hi_cin),
        .i_cut  (w_cut_hi),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    // Only the carries at lane ends are meaningful.
    assign w_unused_cout = ^{w_lo_cout, w_hi_cout};

    always_comb begin
        w_raw_sum = {w_hi_sum, r_s1_sum_lo_q};
        case (r_s1_mode_q)
            MODE_2X: w_lane_ovf = {2'b00, w_hi_cout[c_HALF-1], r_s1_c_half_q};
            MODE_4X: w_lane_ovf = {w_hi_cout[c_HALF-1], w_hi_cout[c_QTR-1],
                                   r_s1_c_half_q, r_s1_c_qtr_q};
            default: w_lane_ovf = {3'b000, w_hi_cout[c_HALF-1]};
        endcase
        w_sat_result = w_raw_sum;
        w_qtr_ovf    = 1'b0;
        // Each quarter saturates with the lane that contains it.
        for (int q = 0; q < 4; q++) begin
            case (r_s1_mode_q)
                MODE_2X: w_qtr_ovf = w_lane_ovf[q / 2];
                MODE_4X: w_qtr_ovf = w_lane_ovf[q];
                default: w_qtr_ovf = w_lane_ovf[0];
            endcase
            if (r_s1_sat_q && w_qtr_ovf) begin
                w_sat_result[q*c_QTR +: c_QTR] = '1;
            end
        end
    end

    always_comb begin
        w_s2_load = !r_s2_valid_q || out_ready;
        w_s1_load = !r_s1_valid_q || w_s2_load;
        in_ready  = w_s1_load && !rst;

        w_s1_valid_d  = r_s1_valid_q;
        w_s1_sum_lo_d = r_s1_sum_lo_q;
        w_s1_c_qtr_d  = r_s1_c_qtr_q;
        w_s1_c_half_d = r_s1_c_half_q;
        w_s1_a_hi_d   = r_s1_a_hi_q;
        w_s1_b_hi_d   = r_s1_b_hi_q;
        w_s1_mode_d   = r_s1_mode_q;
        w_s1_sat_d    = r_s1_sat_q;
        if (w_s1_load) begin
            w_s1_valid_d = in_valid;
            if (in_valid) begin
                w_s1_sum_lo_d = w_lo_sum;
                w_s1_c_qtr_d  = w_lo_cout[c_QTR-1];
                w_s1_c_half_d = w_lo_cout[c_HALF-1];
                w_s1_a_hi_d   = operand_a[WIDTH-1:c_HALF];
                w_s1_b_hi_d   = operand_b[WIDTH-1:c_HALF];
                w_s1_mode_d   = w_mode_in;
                w_s1_sat_d    = sat_en;
            end
        end

        w_s2_valid_d = r_s2_valid_q;
        w_result_d   = r_result_q;
        w_ovf_d      = r_ovf_q;
        if (w_s2_load) begin
            w_s2_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_result_d = w_sat_result;
                w_ovf_d    = w_lane_ovf;
            end
        end

        // A coinciding handshake re-sets its bits after the clear.
        w_sticky_d = (clr_sticky ? 4'b0000 : r_sticky_q)
                   | ((r_s2_valid_q && out_ready) ? r_ovf_q : 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q  <= 1'b0;
            r_s1_sum_lo_q <= '0;
            r_s1_c_qtr_q  <= 1'b0;
            r_s1_c_half_q <= 1'b0;
            r_s1_a_hi_q   <= '0;
            r_s1_b_hi_q   <= '0;
            r_s1_mode_q   <= MODE_1X;
            r_s1_sat_q    <= 1'b0;
            r_s2_valid_q  <= 1'b0;
            r_result_q    <= '0;
            r_ovf_q       <= 4'b0000;
            r_sticky_q    <= 4'b0000;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_sum_lo_q <= w_s1_sum_lo_d;
            r_s1_c_qtr_q  <= w_s1_c_qtr_d;
            r_s1_c_half_q <= w_s1_c_half_d;
            r_s1_a_hi_q   <= w_s1_a_hi_d;
            r_s1_b_hi_q   <= w_s1_b_hi_d;
            r_s1_mode_q   <= w_s1_mode_d;
            r_s1_sat_q    <= w_s1_sat_d;
            r_s2_valid_q  <= w_s2_valid_d;
            r_result_q    <= w_result_d;
            r_ovf_q       <= w_ovf_d;
            r_sticky_q    <= w_sticky_d;
        end
    end

    assign out_valid  = r_s2_valid_q;
    assign result     = r_result_q;
    assign ovf        = r_ovf_q;
    assign ovf_sticky = r_sticky_q;

endmodule

`default_nettype wire
